aes_edn_arb: RTL and testbench

- Parametrised N-way arbiter sharing one EDN entropy interface among the AES-internal PRNGs (clearing, masking, and future consumers such as a key-sideload PRNG).
- Generalises the fixed two-requester, clearing-first priority scheme to NumReq channels.
- Adds a selectable fixed-priority or round-robin mode, burst locking with a fairness limit, and safe draining of EDN handshakes whose requester withdrew.
- Sits between aes_core PRNG request ports and the source side of the EDN req/ack synchroniser, in the AES clock domain.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_edn_arb_sel.sv | 66 ++++++
 rtl/aes_edn_arb.sv | 127 ++++++++++++
 tb/tb_aes_edn_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types for the AES EDN entropy arbiter.
package aes_pkg;

  // Arbitration policy once the current burst owner loses its lock.
  typedef enum logic {
    ArbFixed,
    ArbRoundRobin
  } aes_arb_mode_e;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    Idle,
    Busy,
    Drain
  } aes_edn_arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_edn_arb_sel.sv
// Combinational winner selection for the EDN arbiter. The previous grant keeps
// the channel while it still requests and its burst budget is not used up;
// otherwise another pending requester is chosen by fixed or rotating priority.
module aes_edn_arb_sel
  import aes_pkg::*;
#(
  parameter int            NumReq   = 2,
  parameter aes_arb_mode_e ArbMode  = ArbFixed,
  parameter int            MaxBurst = 4,
  parameter int            IdxW     = 1,
  parameter int            BurstW   = 3
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [IdxW-1:0]   i_rr_ptr,
  input  logic [IdxW-1:0]   i_last_gnt,
  input  logic [BurstW-1:0] i_burst_cnt,
  output logic [NumReq-1:0] o_gnt,
  output logic [IdxW-1:0]   o_gnt_idx,
  output logic              o_restart
);

  logic [NumReq-1:0] w_last_oh;
  logic [NumReq-1:0] w_others;
  logic              w_lock;
  logic              w_found;
  logic [IdxW-1:0]   w_cand;
  int                w_pos;

  // Lock detection: the last owner keeps the channel until its burst budget is spent.
  always_comb begin
    w_last_oh = NumReq'(1) << i_last_gnt;
    w_others  = i_req & ~w_last_oh;
    w_lock    = (|(i_req & w_last_oh)) && (i_burst_cnt < BurstW'(MaxBurst));
  end

  // Search the other pending requesters; if none, the last owner wins with a fresh burst.
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    o_gnt_idx = i_last_gnt;
    o_restart = 1'b0;
    w_found   = 1'b0;
    w_cand    = '0;
    w_pos     = 0;
    if (!w_lock) begin
      o_restart = 1'b1;
      for (int k = 0; k < NumReq; k++) begin
        if (ArbMode == ArbRoundRobin) begin
          w_pos = int'(i_rr_ptr) + k;
          if (w_pos >= NumReq) begin
            w_pos = w_pos - NumReq;
          end
        end else begin
          w_pos = k;
        end
        w_cand = IdxW'(w_pos);
        if (!w_found && w_others[w_cand]) begin
          w_found   = 1'b1;
          o_gnt_idx = w_cand;
        end
      end
    end
  end

  assign o_gnt = NumReq'(1) << o_gnt_idx;

endmodule

// File: rtl/aes_edn_arb.sv
// N-way arbiter sharing one EDN entropy interface among the AES PRNGs.
// One EDN request is issued per granted word; a request is never retracted
// before its ack, so a requester that withdraws is drained and flagged.
module aes_edn_arb
  import aes_pkg::*;
#(
  parameter int            NumReq       = 2,
  parameter int            EntropyWidth = 32,
  parameter aes_arb_mode_e ArbMode      = ArbFixed,
  parameter int            MaxBurst     = 4,
  localparam int           IdxW         = idx_width(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_i,
  output logic [NumReq-1:0]       ack_o,
  output logic [EntropyWidth-1:0] data_o,
  output logic                    edn_req_o,
  input  logic                    edn_ack_i,
  input  logic [EntropyWidth-1:0] edn_data_i,
  output logic [IdxW-1:0]         gnt_idx_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int BurstW = $clog2(MaxBurst + 1);

  aes_edn_arb_state_e r_state, w_state_d;
  logic [IdxW-1:0]    r_gnt, w_gnt_d;
  logic [NumReq-1:0]  r_gnt_oh, w_gnt_oh_d;
  logic [BurstW-1:0]  r_burst_cnt, w_burst_d;
  logic [IdxW-1:0]    r_rr_ptr, w_rr_d;
  logic [NumReq-1:0]  w_sel_gnt;
  logic [IdxW-1:0]    w_sel_idx;
  logic               w_sel_restart;
  logic               w_req_gnt;

  aes_edn_arb_sel #(
    .NumReq  (NumReq),
    .ArbMode (ArbMode),
    .MaxBurst(MaxBurst),
    .IdxW    (IdxW),
    .BurstW  (BurstW)
  ) u_sel (
    .i_req      (req_i),
    .i_rr_ptr   (r_rr_ptr),
    .i_last_gnt (r_gnt),
    .i_burst_cnt(r_burst_cnt),
    .o_gnt      (w_sel_gnt),
    .o_gnt_idx  (w_sel_idx),
    .o_restart  (w_sel_restart)
  );

  // Is the currently granted requester still asking for its word?
  assign w_req_gnt = |(req_i & r_gnt_oh);

  // State, grant, burst and rotation registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= Idle;
      r_gnt       <= '0;
      r_gnt_oh    <= '0;
      r_burst_cnt <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_gnt       <= w_gnt_d;
      r_gnt_oh    <= w_gnt_oh_d;
      r_burst_cnt <= w_burst_d;
      r_rr_ptr    <= w_rr_d;
    end
  end

  // Next-state logic plus the ack, data gating and withdraw-error outputs.
  always_comb begin
    w_state_d  = r_state;
    w_gnt_d    = r_gnt;
    w_gnt_oh_d = r_gnt_oh;
    w_burst_d  = r_burst_cnt;
    w_rr_d     = r_rr_ptr;
    ack_o      = '0;
    data_o     = '0;
    err_o      = 1'b0;
    unique case (r_state)
      Idle: begin
        // A stray edn_ack_i here is a protocol violation and is ignored.
        if (|req_i) begin
          w_state_d  = Busy;
          w_gnt_d    = w_sel_idx;
          w_gnt_oh_d = w_sel_gnt;
          if (w_sel_restart) begin
            w_burst_d = '0;
            w_rr_d    = (int'(w_sel_idx) == NumReq - 1) ? '0 : w_sel_idx + IdxW'(1);
          end
        end
      end
      Busy: begin
        if (w_req_gnt) begin
          if (edn_ack_i) begin
            ack_o     = r_gnt_oh;
            data_o    = edn_data_i;
            w_state_d = Idle;
            if (r_burst_cnt < BurstW'(MaxBurst)) begin
              w_burst_d = r_burst_cnt + 1'b1;
            end
          end
        end else begin
          // Requester withdrew: the word is discarded, the EDN request stays up until acked.
          err_o     = 1'b1;
          w_state_d = edn_ack_i ? Idle : Drain;
        end
      end
      Drain: begin
        if (edn_ack_i) begin
          w_state_d = Idle;
        end
      end
      default: w_state_d = Idle;
    endcase
  end

  assign edn_req_o = (r_state != Idle);
  assign busy_o    = (r_state != Idle);
  assign gnt_idx_o = r_gnt;

endmodule

// File: tb/tb_aes_edn_arb.sv
// Scoreboard bench for aes_edn_arb: a 2-way fixed-priority instance and a
// 4-way round-robin instance, each with an EDN responder, requester driver and
// an ack monitor that pops expected grants predicted by a reference model.
module tb_aes_edn_arb;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Fixed-priority instance: NumReq=2, MaxBurst=4
  logic [1:0]  fx_req, fx_ack;
  logic [31:0] fx_data, fx_edn_data;
  logic        fx_edn_req, fx_edn_ack, fx_busy, fx_err;
  logic [0:0]  fx_gnt_idx;

  // Round-robin instance: NumReq=4, MaxBurst=1
  logic [3:0]  rr_req, rr_ack;
  logic [31:0] rr_data, rr_edn_data;
  logic        rr_edn_req, rr_edn_ack, rr_busy, rr_err;
  logic [1:0]  rr_gnt_idx;

  aes_edn_arb #(.NumReq(2), .EntropyWidth(32), .ArbMode(ArbFixed), .MaxBurst(4)) u_fx (
    .clk_i(clk), .rst_i(rst), .req_i(fx_req), .ack_o(fx_ack), .data_o(fx_data),
    .edn_req_o(fx_edn_req), .edn_ack_i(fx_edn_ack), .edn_data_i(fx_edn_data),
    .gnt_idx_o(fx_gnt_idx), .busy_o(fx_busy), .err_o(fx_err)
  );

  aes_edn_arb #(.NumReq(4), .EntropyWidth(32), .ArbMode(ArbRoundRobin), .MaxBurst(1)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_i(rr_req), .ack_o(rr_ack), .data_o(rr_data),
    .edn_req_o(rr_edn_req), .edn_ack_i(rr_edn_ack), .edn_data_i(rr_edn_data),
    .gnt_idx_o(rr_gnt_idx), .busy_o(rr_busy), .err_o(rr_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard queues: expected grant index and the word the EDN delivered.
  int          exp_fx[$], exp_rr[$];
  logic [31:0] dat_fx[$], dat_rr[$];

  // Requester demand (cumulative words wanted) and words received so far.
  int dem_fx[2] = '{0, 0};
  int got_fx[2] = '{0, 0};
  int dem_rr[4] = '{0, 0, 0, 0};
  int got_rr[4] = '{0, 0, 0, 0};

  // EDN latency range per instance, and manual controls for directed tests.
  int lat_lo_fx = 0, lat_hi_fx = 0, lat_lo_rr = 0, lat_hi_rr = 0;
  bit          fx_auto = 1'b1;
  logic [1:0]  man_req = '0;
  logic        man_ack = 1'b0;
  logic [31:0] man_data = '0;

  // Reference model state: last grant, words served in the current burst, rotation start.
  int m_last[2]  = '{0, 0};
  int m_burst[2] = '{0, 0};
  int m_rr[2]    = '{0, 0};

  // Choose who gets the next word given the pending demand of every requester.
  function automatic int pick(input int d, input int n, input bit rr, input int maxb, input int pend[4]);
    int  w;
    bit  found;
    int  c;
    w = m_last[d];
    if (pend[m_last[d]] > 0 && m_burst[d] < maxb) begin
      w = m_last[d];
    end else begin
      found = 1'b0;
      for (int k = 0; k < n; k++) begin
        c = rr ? (m_rr[d] + k) % n : k;
        if (!found && c != m_last[d] && pend[c] > 0) begin
          found = 1'b1;
          w = c;
        end
      end
      m_burst[d] = 0;
      m_rr[d]    = (w + 1) % n;
    end
    m_burst[d] = (m_burst[d] + 1 > maxb) ? maxb : m_burst[d] + 1;
    m_last[d]  = w;
    return w;
  endfunction

  // Requester drivers: a requester holds req while it still wants words.
  initial begin
    fx_req = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) fx_req[i] = fx_auto ? (dem_fx[i] > got_fx[i]) : man_req[i];
    end
  end

  initial begin
    rr_req = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) rr_req[i] = (dem_rr[i] > got_rr[i]);
    end
  end

  // EDN responders: single-cycle ack after a random number of cycles of edn_req_o.
  initial begin
    int wcnt, lat;
    wcnt = 0; lat = 0;
    fx_edn_ack = 1'b0; fx_edn_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!fx_auto) begin
        fx_edn_ack  = man_ack;
        fx_edn_data = man_data;
      end else if (fx_edn_ack) begin
        fx_edn_ack = 1'b0; fx_edn_data = '0;
      end else if (fx_edn_req) begin
        if (wcnt == 0) lat = $urandom_range(lat_hi_fx, lat_lo_fx);
        if (wcnt >= lat) begin
          fx_edn_ack = 1'b1; fx_edn_data = $urandom;
          dat_fx.push_back(fx_edn_data);
          wcnt = 0;
        end else wcnt++;
      end
    end
  end

  initial begin
    int wcnt, lat;
    wcnt = 0; lat = 0;
    rr_edn_ack = 1'b0; rr_edn_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rr_edn_ack) begin
        rr_edn_ack = 1'b0; rr_edn_data = '0;
      end else if (rr_edn_req) begin
        if (wcnt == 0) lat = $urandom_range(lat_hi_rr, lat_lo_rr);
        if (wcnt >= lat) begin
          rr_edn_ack = 1'b1; rr_edn_data = $urandom;
          dat_rr.push_back(rr_edn_data);
          wcnt = 0;
        end else wcnt++;
      end
    end
  end

  // Monitors: every ack is matched against the scoreboard; otherwise data must be zero.
  initial begin
    int e; logic [31:0] dd;
    forever begin
      @(negedge clk);
      if (fx_ack != '0) begin
        if (exp_fx.size() == 0 || dat_fx.size() == 0) check("fx_unexpected_ack", 64'(fx_ack), 64'd0);
        else begin
          e = exp_fx.pop_front(); dd = dat_fx.pop_front();
          check("fx_ack_onehot", 64'(fx_ack), 64'(1 << e));
          check("fx_gnt_idx", 64'(fx_gnt_idx), 64'(e));
          check("fx_data", 64'(fx_data), 64'(dd));
        end
        for (int i = 0; i < 2; i++) if (fx_ack[i]) got_fx[i]++;
      end else check("fx_data_gated", 64'(fx_data), 64'd0);
      if (fx_auto && fx_err) check("fx_err_spurious", 64'(fx_err), 64'd0);
    end
  end

  initial begin
    int e; logic [31:0] dd;
    forever begin
      @(negedge clk);
      if (rr_ack != '0) begin
        if (exp_rr.size() == 0 || dat_rr.size() == 0) check("rr_unexpected_ack", 64'(rr_ack), 64'd0);
        else begin
          e = exp_rr.pop_front(); dd = dat_rr.pop_front();
          check("rr_ack_onehot", 64'(rr_ack), 64'(1 << e));
          check("rr_gnt_idx", 64'(rr_gnt_idx), 64'(e));
          check("rr_data", 64'(rr_data), 64'(dd));
        end
        for (int i = 0; i < 4; i++) if (rr_ack[i]) got_rr[i]++;
      end else check("rr_data_gated", 64'(rr_data), 64'd0);
      if (rr_err) check("rr_err_spurious", 64'(rr_err), 64'd0);
    end
  end

  // Predict the grant order for a batch of demands, release it, wait for completion.
  task automatic run_round(input int d, input int dem[4], input int lo, input int hi);
    int  pend[4];
    int  n, maxb, w;
    bit  rr, any, done;
    n = (d == 0) ? 2 : 4;
    rr = (d == 1);
    maxb = (d == 0) ? 4 : 1;
    pend = dem;
    for (int i = n; i < 4; i++) pend[i] = 0;
    forever begin
      any = 1'b0;
      for (int i = 0; i < n; i++) if (pend[i] > 0) any = 1'b1;
      if (!any) break;
      w = pick(d, n, rr, maxb, pend);
      pend[w]--;
      if (d == 0) exp_fx.push_back(w); else exp_rr.push_back(w);
    end
    @(negedge clk);
    if (d == 0) begin
      lat_lo_fx = lo; lat_hi_fx = hi;
      for (int i = 0; i < 2; i++) dem_fx[i] += dem[i];
    end else begin
      lat_lo_rr = lo; lat_hi_rr = hi;
      for (int i = 0; i < 4; i++) dem_rr[i] += dem[i];
    end
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      done = 1'b1;
      if (d == 0) begin
        if (exp_fx.size() != 0) done = 1'b0;
        for (int i = 0; i < 2; i++) if (got_fx[i] != dem_fx[i]) done = 1'b0;
      end else begin
        if (exp_rr.size() != 0) done = 1'b0;
        for (int i = 0; i < 4; i++) if (got_rr[i] != dem_rr[i]) done = 1'b0;
      end
    end
    check(d == 0 ? "fx_round_done" : "rr_round_done", 64'(done), 64'd1);
    if (!done) begin
      if (d == 0) begin exp_fx.delete(); for (int i = 0; i < 2; i++) dem_fx[i] = got_fx[i]; end
      else begin exp_rr.delete(); for (int i = 0; i < 4; i++) dem_rr[i] = got_rr[i]; end
    end
    step(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int r0[4];
    rst = 1'b1;
    step(2);
    check("rst_fx_edn_req", 64'(fx_edn_req), 64'd0);
    check("rst_fx_busy", 64'(fx_busy), 64'd0);
    check("rst_fx_gnt_idx", 64'(fx_gnt_idx), 64'd0);
    check("rst_fx_ack", 64'(fx_ack), 64'd0);
    check("rst_fx_err", 64'(fx_err), 64'd0);
    check("rst_rr_edn_req", 64'(rr_edn_req), 64'd0);
    check("rst_rr_busy", 64'(rr_busy), 64'd0);
    check("rst_rr_gnt_idx", 64'(rr_gnt_idx), 64'd0);
    rst = 1'b0;
    step(2);

    // Burst limit under contention, then the waiting requester, then the first resumes.
    run_round(0, '{8, 1, 0, 0}, 2, 2);
    // Round robin with single-word bursts: 0,1,2,3,0,...
    run_round(1, '{2, 2, 2, 2}, 1, 1);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) r0[i] = $urandom_range(5, 0);
      run_round(0, r0, 0, 4);
      for (int i = 0; i < 4; i++) r0[i] = $urandom_range(4, 0);
      run_round(1, r0, 0, 4);
    end

    // Directed tests on the fixed instance with manual EDN control.
    fx_auto = 1'b0;
    step(3);

    // Withdraw one cycle into Busy, EDN answers later: drained, err once, no ack.
    man_req = 2'b01;
    step(1);
    check("wd_latency_low", 64'(fx_edn_req), 64'd0);
    step(1);
    check("wd_edn_req_up", 64'(fx_edn_req), 64'd1);
    check("wd_gnt_idx", 64'(fx_gnt_idx), 64'd0);
    man_req = 2'b00;
    step(1);
    check("wd_err_pulse", 64'(fx_err), 64'd1);
    check("wd_edn_req_busy", 64'(fx_edn_req), 64'd1);
    step(1);
    check("wd_err_once", 64'(fx_err), 64'd0);
    check("wd_edn_req_drain", 64'(fx_edn_req), 64'd1);
    step(4);
    check("wd_edn_req_held", 64'(fx_edn_req), 64'd1);
    man_ack = 1'b1; man_data = 32'hDEADBEEF;
    step(1);
    check("wd_no_ack", 64'(fx_ack), 64'd0);
    check("wd_no_data", 64'(fx_data), 64'd0);
    check("wd_no_err_on_ack", 64'(fx_err), 64'd0);
    man_ack = 1'b0; man_data = '0;
    step(1);
    check("wd_idle_busy", 64'(fx_busy), 64'd0);
    check("wd_idle_edn_req", 64'(fx_edn_req), 64'd0);

    // Withdraw in the same cycle as the EDN ack.
    man_req = 2'b10;
    step(2);
    check("sc_gnt_idx", 64'(fx_gnt_idx), 64'd1);
    man_ack = 1'b1; man_data = 32'hCAFEF00D; man_req = 2'b00;
    step(1);
    check("sc_no_ack", 64'(fx_ack), 64'd0);
    check("sc_err", 64'(fx_err), 64'd1);
    check("sc_no_data", 64'(fx_data), 64'd0);
    man_ack = 1'b0; man_data = '0;
    step(1);
    check("sc_idle", 64'(fx_busy), 64'd0);
    check("sc_err_clear", 64'(fx_err), 64'd0);

    // EDN ack while Idle is ignored.
    man_ack = 1'b1; man_data = 32'h12345678;
    step(1);
    check("idle_ack_no_ack", 64'(fx_ack), 64'd0);
    check("idle_ack_no_data", 64'(fx_data), 64'd0);
    check("idle_ack_busy", 64'(fx_busy), 64'd0);
    man_ack = 1'b0; man_data = '0;
    step(1);
    check("idle_ack_still_idle", 64'(fx_busy), 64'd0);
    check("idle_ack_no_edn_req", 64'(fx_edn_req), 64'd0);

    // Reset while draining, then a fresh grant to requester 1.
    man_req = 2'b01;
    step(2);
    man_req = 2'b00;
    step(2);
    check("rd_in_drain", 64'(fx_busy), 64'd1);
    man_req = 2'b10;
    rst = 1'b1;
    #1;
    check("rd_edn_req", 64'(fx_edn_req), 64'd0);
    check("rd_busy", 64'(fx_busy), 64'd0);
    check("rd_gnt_idx", 64'(fx_gnt_idx), 64'd0);
    check("rd_err", 64'(fx_err), 64'd0);
    check("rd_ack", 64'(fx_ack), 64'd0);
    check("rd_data", 64'(fx_data), 64'd0);
    step(1);
    rst = 1'b0;
    check("rd_release_low", 64'(fx_edn_req), 64'd0);
    step(1);
    check("rd_edn_req_rise", 64'(fx_edn_req), 64'd1);
    check("rd_gnt_idx_1", 64'(fx_gnt_idx), 64'd1);
    exp_fx.push_back(1);
    dat_fx.push_back(32'hA5A50001);
    man_ack = 1'b1; man_data = 32'hA5A50001;
    step(1);
    man_ack = 1'b0; man_data = '0; man_req = 2'b00;
    step(3);
    check("final_fx_queue_empty", 64'(exp_fx.size()), 64'd0);
    check("final_fx_idle", 64'(fx_busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
